// File: rtl/interface_change_s2p.sv
// Serial-to-parallel write converter: gathers strobed serial bits into DATA_W-bit
// words and presents each completed word with a one-cycle write pulse.
module interface_change_s2p #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              wra_n,
    input  logic              da,
    output logic [DATA_W-1:0] db,
    output logic              wrb,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] db_q, db_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wrb_q, wrb_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] shifted;

    // Next-state: accept a bit, complete a word, or abort a partial word on a strobe gap.
    always_comb begin
        sr_d    = sr_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        wrb_d   = 1'b0;
        ferr_d  = 1'b0;
        shifted = sr_q;
        if (MSB_FIRST) begin
            shifted = {sr_q[DATA_W-2:0], da};
        end else begin
            shifted = {da, sr_q[DATA_W-1:1]};
        end
        if (!wra_n) begin
            sr_d = shifted;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                db_d  = shifted;
                wrb_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            sr_d   = '0;
            cnt_d  = '0;
            ferr_d = 1'b1;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
            wrb_q  <= 1'b0;
            busy_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            wrb_q  <= wrb_d;
            busy_q <= busy_d;
            ferr_q <= ferr_d;
        end
    end

    assign db        = db_q;
    assign wrb       = wrb_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_interface_change_s2p.sv
// Bench for interface_change_s2p: both bit orders side by side, directed tables,
// multi-cycle corner sequences and randomized traffic against a bit-queue model.
module tb_interface_change_s2p;

    localparam int unsigned DATA_W = 8;

    logic              clka;
    logic              rst_n;
    logic              wra_n;
    logic              da;
    logic [DATA_W-1:0] db_m, db_l;
    logic              wrb_m, wrb_l, busy_m, busy_l, ferr_m, ferr_l;

    interface_change_s2p #(.DATA_W(DATA_W), .MSB_FIRST(1'b1)) dut (
        .clka(clka), .rst_n(rst_n), .wra_n(wra_n), .da(da),
        .db(db_m), .wrb(wrb_m), .busy(busy_m), .frame_err(ferr_m)
    );

    interface_change_s2p #(.DATA_W(DATA_W), .MSB_FIRST(1'b0)) dut_l (
        .clka(clka), .rst_n(rst_n), .wra_n(wra_n), .da(da),
        .db(db_l), .wrb(wrb_l), .busy(busy_l), .frame_err(ferr_l)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int checks   = 0;
    int failures = 0;

    // Reference model: the pending bits of the current word, in arrival order.
    logic              q[$];
    logic [DATA_W-1:0] m_db, m_db_l;
    logic              m_wrb, m_busy, m_ferr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_db   = '0;
        m_db_l = '0;
        m_wrb  = 1'b0;
        m_busy = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic d);
        m_wrb  = 1'b0;
        m_ferr = 1'b0;
        if (!w) begin
            q.push_back(d);
            if (q.size() == DATA_W) begin
                for (int i = 0; i < DATA_W; i++) begin
                    m_db[DATA_W-1-i] = q[i];
                    m_db_l[i]        = q[i];
                end
                m_wrb = 1'b1;
                q.delete();
            end
        end else if (q.size() != 0) begin
            m_ferr = 1'b1;
            q.delete();
        end
        m_busy = (q.size() != 0);
    endtask

    // Drive one cycle away from the edge, then compare both DUTs to the model.
    task automatic step(input logic w, input logic d);
        @(negedge clka);
        wra_n = w;
        da    = d;
        @(posedge clka);
        model_edge(w, d);
        #1;
        chk("db_msb",    32'(db_m),   32'(m_db));
        chk("db_lsb",    32'(db_l),   32'(m_db_l));
        chk("wrb_msb",   32'(wrb_m),  32'(m_wrb));
        chk("wrb_lsb",   32'(wrb_l),  32'(m_wrb));
        chk("busy_msb",  32'(busy_m), 32'(m_busy));
        chk("busy_lsb",  32'(busy_l), 32'(m_busy));
        chk("ferr_msb",  32'(ferr_m), 32'(m_ferr));
        chk("ferr_lsb",  32'(ferr_l), 32'(m_ferr));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        @(negedge clka);
        wra_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_db_msb", 32'(db_m),   32'h0);
        chk("rst_db_lsb", 32'(db_l),   32'h0);
        chk("rst_wrb",    32'(wrb_m),  32'h0);
        chk("rst_busy",   32'(busy_m), 32'h0);
        chk("rst_ferr",   32'(ferr_m), 32'h0);
        model_reset();
        @(negedge clka);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic              w;
        logic              d;
        logic [DATA_W-1:0] db;
        logic [DATA_W-1:0] db_l;
        logic              wrb;
        logic              busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DATA_W-1:0] word;
        int                npulse;
        int                nferr;
        int                last_pulse;

        rst_n = 1'b0;
        wra_n = 1'b1;
        da    = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        pulse_reset();

        // Single word 1,0,1,1,0,0,1,0: 0xB2 MSB-first, 0x4D LSB-first.
        tbl[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].w, tbl[i].d);
            chk($sformatf("tbl%0d_db", i),   32'(db_m),   32'(tbl[i].db));
            chk($sformatf("tbl%0d_dbl", i),  32'(db_l),   32'(tbl[i].db_l));
            chk($sformatf("tbl%0d_wrb", i),  32'(wrb_m),  32'(tbl[i].wrb));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_m), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_ferr", i), 32'(ferr_m), 32'h0);
        end

        // Back-to-back 0xA5 then 0x3C, strobe held low throughout.
        npulse = 0;
        last_pulse = -100;
        for (int i = 0; i < 16; i++) begin
            word = (i < 8) ? 8'hA5 : 8'h3C;
            step(1'b0, word[7 - (i % 8)]);
            if (wrb_m) begin
                npulse++;
                if (npulse == 2) chk("b2b_spacing", 32'(i - last_pulse), 32'd8);
                last_pulse = i;
            end
            chk("b2b_ferr", 32'(ferr_m), 32'h0);
            if (i == 7)  chk("b2b_db0", 32'(db_m), 32'hA5);
            if (i == 15) chk("b2b_db1", 32'(db_m), 32'h3C);
        end
        chk("b2b_pulses", 32'(npulse), 32'd2);

        // Abort after 5 bits, then a full 0xFF word.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("abort_ferr", 32'(ferr_m), 32'h1);
        chk("abort_wrb",  32'(wrb_m),  32'h0);
        chk("abort_db",   32'(db_m),   32'h3C);
        step(1'b1, 1'b0);
        chk("abort_ferr_clr", 32'(ferr_m), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        chk("after_abort_db", 32'(db_m), 32'hFF);

        // Reset mid-word: 3 bits lost, then 0x81.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        pulse_reset();
        npulse = 0;
        nferr  = 0;
        word   = 8'h81;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, word[7 - i]);
            if (wrb_m)  npulse++;
            if (ferr_m) nferr++;
        end
        step(1'b1, 1'b0);
        if (ferr_m) nferr++;
        chk("rstmid_pulses", 32'(npulse), 32'd1);
        chk("rstmid_ferr",   32'(nferr),  32'd0);
        chk("rstmid_db",     32'(db_m),   32'h81);
        chk("rstmid_db_lsb", 32'(db_l),   32'h81);

        // Randomized traffic with occasional strobe gaps.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
